// File: rtl/fifo_port_sched_if.sv
// Handshake bundle between the scheduler, its two producers, its consumer and the FIFO ports.
interface fifo_port_sched_if #(
  parameter int DW = 8,
  parameter int CW = 5
);
  logic          ReqA;
  logic [DW-1:0] DinA;
  logic          AckA;
  logic          ReqB;
  logic [DW-1:0] DinB;
  logic          AckB;
  logic          RdReq;
  logic [DW-1:0] RdData;
  logic          RdValid;
  logic [CW-1:0] Level;
  logic          Wen;
  logic          Ren;
  logic [DW-1:0] FDin;
  logic [DW-1:0] FDout;

  // master: the scheduler itself
  modport master (
    input  ReqA, DinA, ReqB, DinB, RdReq, FDout,
    output AckA, AckB, RdData, RdValid, Level, Wen, Ren, FDin
  );

  // slave: producers, consumer and FIFO around the scheduler
  modport slave (
    output ReqA, DinA, ReqB, DinB, RdReq, FDout,
    input  AckA, AckB, RdData, RdValid, Level, Wen, Ren, FDin
  );
endinterface

// File: rtl/fifo_port_sched.sv
// Round-robin write-port sharing for two producers plus read-port driving for one consumer,
// issuing at most one FIFO operation per cycle and tracking occupancy locally.
module fifo_port_sched #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input logic              clk,
  input logic              rst,
  fifo_port_sched_if.master bus
);

  // Op state encoding is {Wen,Ren}; the register drives the FIFO strobes directly.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10
  } op_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  op_e           op_q;
  op_e           op_last_q;
  src_e          rr_last_q;
  logic [DW-1:0] fdin_q;
  logic          acka_q;
  logic          ackb_q;
  logic          rdvalid_q;
  logic [CW-1:0] level_q;

  logic          elig_a;
  logic          elig_b;
  logic          wr_ok;
  logic          rd_ok;
  logic          do_wr;
  logic          do_rd;
  logic          grant_b;
  logic [CW-1:0] level_d;

  always_comb begin
    elig_a  = bus.ReqA & ~acka_q;
    elig_b  = bus.ReqB & ~ackb_q;
    wr_ok   = (elig_a | elig_b) & (level_q < CW'(DEPTH));
    rd_ok   = bus.RdReq & (level_q != '0);
    // On contention, alternate against whichever op went last.
    do_wr   = wr_ok & (~rd_ok | (op_last_q == OP_RD));
    do_rd   = rd_ok & ~do_wr;
    grant_b = elig_b & (~elig_a | (rr_last_q == SRC_A));
    level_d = level_q;
    if (do_wr) begin
      level_d = level_q + CW'(1);
    end else if (do_rd) begin
      level_d = level_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q      <= OP_IDLE;
      op_last_q <= OP_RD;
      rr_last_q <= SRC_B;
      fdin_q    <= '0;
      acka_q    <= 1'b0;
      ackb_q    <= 1'b0;
      rdvalid_q <= 1'b0;
      level_q   <= '0;
    end else begin
      acka_q    <= 1'b0;
      ackb_q    <= 1'b0;
      rdvalid_q <= op_q[0];
      level_q   <= level_d;
      if (do_wr) begin
        op_q      <= OP_WR;
        op_last_q <= OP_WR;
        if (grant_b) begin
          fdin_q    <= bus.DinB;
          ackb_q    <= 1'b1;
          rr_last_q <= SRC_B;
        end else begin
          fdin_q    <= bus.DinA;
          acka_q    <= 1'b1;
          rr_last_q <= SRC_A;
        end
      end else if (do_rd) begin
        op_q      <= OP_RD;
        op_last_q <= OP_RD;
      end else begin
        op_q <= OP_IDLE;
      end
    end
  end

  assign bus.Wen     = op_q[1];
  assign bus.Ren     = op_q[0];
  assign bus.FDin    = fdin_q;
  assign bus.AckA    = acka_q;
  assign bus.AckB    = ackb_q;
  assign bus.RdValid = rdvalid_q;
  assign bus.Level   = level_q;
  assign bus.RdData  = bus.FDout;

endmodule
